// File: rtl/alu_exec_unit.sv
// ALU execution unit: registered single-cycle ALU operations plus an iterative
// shift-add unsigned multiply that writes HI/LO and stalls requests while busy.
module alu_exec_unit #(
    parameter int MUL_STEP = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alu_ctrl,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MUL_CYC = 32 / MUL_STEP;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic signed [31:0] a_s, b_s;
    logic        [31:0] sum, diff;
    logic        [31:0] alu_res;
    logic               alu_ovf, alu_ill;
    logic        [63:0] acc, acc_next, mcand, partial;
    logic        [31:0] mplier;
    logic        [5:0]  cnt;

    function automatic logic add_ovf(input logic [31:0] a, b, s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    function automatic logic sub_ovf(input logic [31:0] a, b, d);
        return (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

    assign a_s      = op_a;
    assign b_s      = op_b;
    assign sum      = op_a + op_b;
    assign diff     = op_a - op_b;
    assign in_ready = (state == IDLE);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            6'h00: alu_res = op_a & op_b;
            6'h01: alu_res = op_a | op_b;
            6'h02: begin
                alu_res = sum;
                alu_ovf = add_ovf(op_a, op_b, sum);
            end
            6'h03: alu_res = sum;
            6'h04: alu_res = op_a ^ op_b;
            6'h06: begin
                alu_res = diff;
                alu_ovf = sub_ovf(op_a, op_b, diff);
            end
            6'h07: alu_res = {31'b0, a_s < b_s};
            6'h08: alu_res = {31'b0, op_a < op_b};
            6'h09: alu_res = {op_b[15:0], 16'h0};
            6'h0A: alu_res = op_b << 1;
            6'h0B: alu_res = op_b << 2;
            6'h0C: alu_res = op_b << 8;
            6'h0D: alu_res = op_b >> 1;
            6'h0E: alu_res = op_b >> 2;
            6'h0F: alu_res = op_b >> 8;
            6'h10: alu_res = b_s >>> 1;
            6'h11: alu_res = b_s >>> 2;
            6'h12: alu_res = b_s >>> 8;
            default: alu_ill = 1'b1;
        endcase
    end

    // Partial product for the MUL_STEP multiplier bits retired this cycle
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
    end

    assign acc_next = acc + partial;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (alu_ctrl == 6'h13) begin
                            state  <= MUL;
                            acc    <= '0;
                            mcand  <= {32'b0, op_a};
                            mplier <= op_b;
                            cnt    <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            illegal   <= alu_ill;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + 6'd1;
                    // Last iteration: publish the product on the same edge
                    if (cnt == 6'(MUL_CYC - 1)) begin
                        state     <= IDLE;
                        {hi, lo}  <= acc_next;
                        result    <= acc_next[31:0];
                        zero      <= (acc_next[31:0] == '0);
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: table of single-cycle vectors plus
// hand-written multiply, stall and mid-multiply reset sequences.
module tb_alu_exec_unit;

    logic        clock, reset_n;
    logic        in_valid, in_valid4;
    logic [5:0]  alu_ctrl;
    logic [31:0] op_a, op_b;

    logic        in_ready, out_valid, zero, overflow, illegal;
    logic [31:0] result, hi, lo;
    logic        in_ready4, out_valid4, zero4, overflow4, illegal4;
    logic [31:0] result4, hi4, lo4;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.MUL_STEP(1)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    alu_exec_unit #(.MUL_STEP(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid4),
        .result(result4), .zero(zero4), .overflow(overflow4), .illegal(illegal4),
        .hi(hi4), .lo(lo4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ovf;
        logic        ill;
    } vec_t;

    vec_t vecs[21];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        int lat, busy, pulses;

        vecs[0]  = '{6'h02, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{6'h06, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'h12, 32'h00000000, 32'h80000000, 32'hFF800000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'h30, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{6'h05, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{6'h09, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{6'h01, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'h04, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{6'h03, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{6'h06, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{6'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{6'h08, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{6'h0C, 32'h00000000, 32'h00ABCDEF, 32'hABCDEF00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{6'h0D, 32'h00000000, 32'h80000001, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{6'h11, 32'h00000000, 32'h80000000, 32'hE0000000, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{6'h0A, 32'h00000000, 32'h80000001, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{6'h02, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{6'h0F, 32'h00000000, 32'hFF000000, 32'h00FF0000, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{6'h0B, 32'h00000000, 32'h00000001, 32'h00000004, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{6'h10, 32'h00000000, 32'h40000000, 32'h20000000, 1'b0, 1'b0, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        alu_ctrl  = '0;
        op_a      = '0;
        op_b      = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, overflow, illegal}, 0);
        chk("rst_hilo", {hi, lo}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Back-to-back single-cycle vectors, one accepted per cycle
        for (int i = 0; i < 21; i++) begin
            alu_ctrl = vecs[i].ctrl;
            op_a     = vecs[i].a;
            op_b     = vecs[i].b;
            in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            step();
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
            chk($sformatf("v%0d_overflow", i), overflow, vecs[i].ovf);
            chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
            chk($sformatf("v%0d_hilo", i), {hi, lo}, 0);
        end
        in_valid = 1'b0;
        step();
        chk("idle_out_valid", out_valid, 0);

        // MULTU 0xFFFFFFFF x 0xFFFFFFFF, MUL_STEP=1
        alu_ctrl = 6'h13;
        op_a     = 32'hFFFFFFFF;
        op_b     = 32'hFFFFFFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_a     = 32'h0;
        op_b     = 32'h0;
        lat  = 0;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            step();
            lat++;
        end
        chk("mul1_latency", lat, 32);
        chk("mul1_busy_cycles", busy, 32);
        chk("mul1_out_valid", out_valid, 1);
        chk("mul1_hi", hi, 32'hFFFFFFFE);
        chk("mul1_lo", lo, 32'h00000001);
        chk("mul1_result", result, 32'h00000001);
        chk("mul1_flags", {zero, overflow, illegal}, 0);
        chk("mul1_in_ready", in_ready, 1);
        step();
        chk("mul1_pulse", out_valid, 0);

        // Same product with MUL_STEP=4
        alu_ctrl  = 6'h13;
        op_a      = 32'hFFFFFFFF;
        op_b      = 32'hFFFFFFFF;
        in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 100) begin
            step();
            lat++;
        end
        chk("mul4_latency", lat, 8);
        chk("mul4_hilo", {hi4, lo4}, 64'hFFFFFFFE_00000001);
        chk("mul4_result", result4, 32'h00000001);
        chk("mul4_in_ready", in_ready4, 1);

        // ADD held during a multiply waits for in_ready
        alu_ctrl = 6'h13;
        op_a     = 32'h12345678;
        op_b     = 32'h00000010;
        in_valid = 1'b1;
        step();
        alu_ctrl = 6'h02;
        op_a     = 32'h00000001;
        op_b     = 32'h00000002;
        lat = 0;
        pulses = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("mul2_latency", lat, 32);
        chk("mul2_hilo", {hi, lo}, 64'h00000001_23456780);
        chk("mul2_result", result, 32'h23456780);
        step();
        in_valid = 1'b0;
        chk("held_add_out_valid", out_valid, 1);
        chk("held_add_result", result, 32'h00000003);
        chk("held_add_hilo", {hi, lo}, 64'h00000001_23456780);
        step();
        chk("held_add_pulse", out_valid, 0);

        // Reset during iteration 10 aborts the multiply
        alu_ctrl = 6'h13;
        op_a     = 32'hFFFFFFFF;
        op_b     = 32'hFFFFFFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        chk("abort_busy", in_ready, 0);
        reset_n = 1'b0;
        #2;
        chk("abort_rst_hilo", {hi, lo}, 0);
        chk("abort_rst_out_valid", out_valid, 0);
        #2;
        reset_n = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) pulses++;
        end
        chk("abort_no_out_valid", pulses, 0);
        chk("abort_hilo_after", {hi, lo}, 0);
        chk("abort_result_after", result, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution unit that consumes the 6-bit ALU control code produced by the ALU controller and performs the selected operation on two 32-bit operands.
- Single-cycle operations return a registered result one cycle after acceptance.
- Unsigned multiply (code 0x13) runs as an iterative shift-add sequence that writes the HI/LO registers and back-pressures the pipeline through in_ready.

Parameters:
MUL_STEP, 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8. Multiply takes MUL_CYC = 32/MUL_STEP cycles.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request this cycle
alu_ctrl  input  6  ALU control code
op_a  input  32  operand A (rs)
op_b  input  32  operand B (rt)
out_valid  output  1  single-cycle pulse; result and flags valid
result  output  32  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow, codes 0x02 and 0x06 only
illegal  output  1  alu_ctrl was not a defined code
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, reset_n=0): FSM enters IDLE. in_ready=1. out_valid=0. result=0, zero=0, overflow=0, illegal=0, hi=0, lo=0. Multiply iteration state is cleared.
- Reset asserted mid-multiply: the multiply aborts and no out_valid is produced. hi and lo read 0 after reset.
- Handshake: a request is accepted on a rising edge where in_valid & in_ready. There is no output back-pressure; out_valid is a one-cycle pulse.
- FSM has two states: IDLE and MUL.
  - IDLE: in_ready=1.
  - Accepting code 0x13 moves IDLE to MUL.
  - Accepting any other code stays in IDLE. result and flags are registered at that edge, and out_valid=1 for the following cycle.
  - Back-to-back single-cycle requests are sustained every cycle.
- Single-cycle codes (shifts act on op_b):
  - 0x00 AND, 0x01 OR, 0x04 XOR.
  - 0x02 ADD (signed): overflow when operand signs match and result sign differs.
  - 0x03 ADDU: no overflow.
  - 0x06 SUB (a−b): overflow per two's-complement rule.
  - 0x07 SLT (signed): result 1 or 0.
  - 0x08 SLTU: result 1 or 0.
  - 0x09 LUI: result = {op_b[15:0], 16'h0}.
  - 0x0A/0x0B/0x0C: SLL by 1/2/8.
  - 0x0D/0x0E/0x0F: SRL by 1/2/8.
  - 0x10/0x11/0x12: SRA by 1/2/8.
- Any other code, including 0x30: result=0, zero=1, illegal=1 with out_valid. No state change.
- overflow=0 for all codes other than 0x02 and 0x06.
- MUL state:
  - The accept edge latches op_a, op_b and clears a 64-bit accumulator. in_ready=0 while in MUL.
  - Each cycle retires MUL_STEP bits of op_b (LSB first) into the accumulator.
  - After MUL_CYC iterations, {hi,lo} = op_a*op_b (unsigned 64-bit) at the same edge that raises out_valid. result = lo of the new product, zero = (result==0), overflow=0.
  - FSM returns to IDLE at that edge, so in_ready=1 in the out_valid cycle.
  - Latency with MUL_STEP=1: accept at edge k, out_valid high in the cycle after edge k+32.
- hi and lo change only on multiply completion and reset. Single-cycle ops leave them untouched.
- in_valid while in_ready=0 is ignored; the requester must hold the request.
- Inputs are sampled only at the accept edge; operand changes during MUL have no effect.

Test Plan:
- Reset, then ADD (0x02) 0x7FFFFFFF + 0x00000001 → next cycle out_valid=1, result=0x80000000, overflow=1, zero=0; hi=lo=0.
- SUB (0x06) 5−5, then SRA8 (0x12) on op_b=0x80000000 on consecutive cycles → result=0/zero=1, then result=0xFF800000. Two consecutive out_valid pulses; in_ready stays 1.
- MULTU (0x13) 0xFFFFFFFF × 0xFFFFFFFF, MUL_STEP=1:
  - in_ready=0 for 32 cycles.
  - Then out_valid=1 with hi=0xFFFFFFFE, lo=0x00000001, result=0x00000001.
  - Repeat with MUL_STEP=4: latency is 8 cycles.
- in_valid held high with ADD during a multiply → ignored until in_ready=1, then accepted. The ADD result appears the cycle after the multiply's out_valid; hi/lo keep the product.
- reset_n pulsed low at iteration 10 of a multiply → no out_valid; hi=lo=0; in_ready=1 immediately after release.
- Codes 0x30 and 0x05 → result=0, zero=1, illegal=1; LUI (0x09) op_b=0x1234 → result=0x12340000, illegal=0.
